// File: rtl/stream_hdr_pkg.sv
// stream_hdr_pkg: shared FSM state type and header field offsets
// for the stream header inserter.
package stream_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int SEQ_OFS   = 0;
  localparam int MAGIC_OFS = 4;

endpackage

// File: rtl/keep_count.sv
// keep_count: byte-lane keep <-> byte count conversion.
// Ports: keep->count (popcount of a contiguous keep), n->mask (n low ones).
module keep_count #(
  parameter int NB = 64,
  parameter int CW = $clog2(NB + 1)
) (
  input  logic [NB-1:0] keep,
  output logic [CW-1:0] count,
  input  logic [CW-1:0] n,
  output logic [NB-1:0] mask
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NB; i++)
      count = count + CW'(keep[i]);
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++)
      mask[i] = (i < int'(n));
  end

endmodule

// File: rtl/stream_header_inserter.sv
// stream_header_inserter: prepends a seq/magic header to each AXI-stream
// packet, shifting payload up by HDR_BYTES; optional HDR_BYPASS_EN adds
// hdr_bypass (sampled on first beat) to pass a packet unmodified.
// Ports: clk, resetn (async, active low), AXIS_IN_* slave, AXIS_OUT_* master.
module stream_header_inserter
  import stream_hdr_pkg::*;
#(
  parameter int          DW        = 512,
  parameter int          HDR_BYTES = 8,
  parameter logic [31:0] HDR_MAGIC = 32'hC0DE_0001
) (
  input  logic            clk,
  input  logic            resetn,
`ifdef HDR_BYPASS_EN
  input  logic            hdr_bypass,
`endif
  input  logic [DW-1:0]   AXIS_IN_TDATA,
  input  logic            AXIS_IN_TVALID,
  output logic            AXIS_IN_TREADY,
  input  logic [DW/8-1:0] AXIS_IN_TKEEP,
  input  logic            AXIS_IN_TLAST,
  output logic [DW-1:0]   AXIS_OUT_TDATA,
  output logic            AXIS_OUT_TVALID,
  input  logic            AXIS_OUT_TREADY,
  output logic [DW/8-1:0] AXIS_OUT_TKEEP,
  output logic            AXIS_OUT_TLAST
);

  localparam int NB   = DW / 8;
  localparam int ROOM = NB - HDR_BYTES;
  localparam int HW   = HDR_BYTES * 8;
  localparam int CW   = $clog2(NB + 1);

  state_t          state;
  logic [31:0]     seq;
  logic [HW-1:0]   carry;
  logic [NB-1:0]   flush_keep_q;

  logic [CW-1:0]   n_in;
  logic [CW-1:0]   last_n;
  logic [CW-1:0]   flush_n;
  logic [CW-1:0]   unused_cnt;
  logic [NB-1:0]   last_keep;
  logic [NB-1:0]   flush_keep;
  logic [HW-1:0]   hdr;
  logic [DW-1:0]   shifted;
  logic            out_free;
  logic            in_fire;
  logic            is_long;
  logic            byp_now;

  keep_count #(.NB(NB)) u_kc_in (
    .keep  (AXIS_IN_TKEEP),
    .count (n_in),
    .n     (last_n),
    .mask  (last_keep)
  );

  keep_count #(.NB(NB)) u_kc_fl (
    .keep  ('0),
    .count (unused_cnt),
    .n     (flush_n),
    .mask  (flush_keep)
  );

  assign last_n  = n_in + CW'(HDR_BYTES);
  assign flush_n = n_in - CW'(ROOM);
  assign is_long = n_in > CW'(ROOM);

  always_comb begin
    hdr = '0;
    hdr[SEQ_OFS*8 +: 32]   = seq;
    hdr[MAGIC_OFS*8 +: 32] = HDR_MAGIC;
  end

  assign shifted = {AXIS_IN_TDATA[ROOM*8-1:0],
                    (state == IDLE) ? hdr : carry};

  assign out_free       = !AXIS_OUT_TVALID || AXIS_OUT_TREADY;
  assign AXIS_IN_TREADY = out_free && (state != FLUSH);
  assign in_fire        = AXIS_IN_TVALID && AXIS_IN_TREADY;

`ifdef HDR_BYPASS_EN
  logic byp_q;
  assign byp_now = byp_q || (state == IDLE && hdr_bypass);
`else
  assign byp_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      seq             <= '0;
      carry           <= '0;
      flush_keep_q    <= '0;
      AXIS_OUT_TDATA  <= '0;
      AXIS_OUT_TVALID <= 1'b0;
      AXIS_OUT_TKEEP  <= '0;
      AXIS_OUT_TLAST  <= 1'b0;
`ifdef HDR_BYPASS_EN
      byp_q           <= 1'b0;
`endif
    end else if (state == FLUSH) begin
      if (out_free) begin
        AXIS_OUT_TDATA  <= {{(DW-HW){1'b0}}, carry};
        AXIS_OUT_TKEEP  <= flush_keep_q;
        AXIS_OUT_TLAST  <= 1'b1;
        AXIS_OUT_TVALID <= 1'b1;
        state           <= IDLE;
      end
    end else if (in_fire) begin
      AXIS_OUT_TVALID <= 1'b1;
      if (byp_now) begin
        AXIS_OUT_TDATA <= AXIS_IN_TDATA;
        AXIS_OUT_TKEEP <= AXIS_IN_TKEEP;
        AXIS_OUT_TLAST <= AXIS_IN_TLAST;
`ifdef HDR_BYPASS_EN
        byp_q          <= !AXIS_IN_TLAST;
`endif
      end else begin
        AXIS_OUT_TDATA <= shifted;
        carry          <= AXIS_IN_TDATA[DW-1 -: HW];
        if (!AXIS_IN_TLAST) begin
          AXIS_OUT_TKEEP <= '1;
          AXIS_OUT_TLAST <= 1'b0;
          state          <= BODY;
        end else begin
          seq <= seq + 32'd1;
          if (is_long) begin
            // residual bytes don't fit: emit them next cycle
            AXIS_OUT_TKEEP <= '1;
            AXIS_OUT_TLAST <= 1'b0;
            flush_keep_q   <= flush_keep;
            state          <= FLUSH;
          end else begin
            AXIS_OUT_TKEEP <= last_keep;
            AXIS_OUT_TLAST <= 1'b1;
            state          <= IDLE;
          end
        end
      end
    end else if (out_free) begin
      AXIS_OUT_TVALID <= 1'b0;
    end
  end

endmodule

// File: doc/stream_header_inserter.md
STREAM_HEADER_INSERTER -- requirements
Module: stream_header_inserter

Interface
REQ-001 SHALL have parameter DW, default 512: AXI-stream data width in bits, a multiple of 64.
REQ-002 SHALL have parameter HDR_BYTES, default 8: header length in bytes, 8 <= HDR_BYTES < DW/8.
REQ-003 SHALL have parameter HDR_MAGIC, default 32'hC0DE_0001: constant header tag.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  clock; resetn  input  1  reset.
REQ-005 SHALL have AXIS_IN_TDATA  input  DW  payload data.
REQ-006 SHALL have AXIS_IN_TVALID input 1, AXIS_IN_TREADY output 1, AXIS_IN_TKEEP input DW/8, and AXIS_IN_TLAST input 1.
REQ-007 SHALL have AXIS_OUT_TDATA output DW, AXIS_OUT_TVALID output 1, AXIS_OUT_TREADY input 1, AXIS_OUT_TKEEP output DW/8, and AXIS_OUT_TLAST output 1; all outputs registered.

Function
REQ-008 SHALL prepend an HDR_BYTES header to every packet and shift the payload up by HDR_BYTES bytes.
REQ-009 SHALL fill header bytes as follows: bytes 0-3 = 32-bit packet sequence number (little-endian), bytes 4-7 = HDR_MAGIC (little-endian), remaining header bytes = 0.
REQ-010 SHALL reset the sequence counter to 0, increment it on each accepted TLAST input beat, and wrap from 2^32-1 to 0.
REQ-011 SHALL use an FSM with states IDLE (expecting first beat), BODY (mid-packet), and FLUSH (emitting the residual beat).
REQ-012 SHALL build each output beat as {input low DW/8-HDR_BYTES bytes, carry}, where carry is the header in IDLE and otherwise the previous beat's top HDR_BYTES bytes.
REQ-013 SHALL assert OUT_TLAST in the same beat when the last input beat holds n <= DW/8-HDR_BYTES bytes, with OUT_TKEEP = n+HDR_BYTES low ones, then go to IDLE.
REQ-014 SHALL go to FLUSH when n > DW/8-HDR_BYTES, emitting one extra beat with the n-(DW/8-HDR_BYTES) carried bytes, contiguous low keep, and TLAST, then go to IDLE.
REQ-015 SHALL drive AXIS_IN_TREADY = (!AXIS_OUT_TVALID || AXIS_OUT_TREADY) && state != FLUSH.
REQ-016 SHALL give an accepted input beat a latency of one cycle to OUT_TVALID.
REQ-017 SHALL sustain a throughput of one beat per cycle, except for one extra cycle per FLUSH packet.
REQ-018 SHALL hold OUT_TDATA, OUT_TKEEP, and OUT_TLAST stable while OUT_TVALID && !OUT_TREADY.
REQ-019 SHALL accept input TKEEP as all ones on non-last beats and contiguous from bit 0 and nonzero on last beats; other patterns give an undefined output.
REQ-020 SHALL allow back-to-back packets with no idle cycle when no FLUSH occurs.

Reset
REQ-021 SHALL, while resetn is low, force OUT_TVALID=0, OUT_TDATA=0, OUT_TKEEP=0, OUT_TLAST=0, state=IDLE, carry=0, and the sequence counter to 0.
REQ-022 SHALL, on reset mid-packet, discard the partial packet; the next accepted beat starts a new packet with sequence number 0.

Configuration
REQ-023 SHALL, when HDR_BYPASS_EN is defined, add hdr_bypass  input  1, sampled on a packet's first beat; if it is 1, the packet passes unmodified, one cycle latency, with no header, and the counter is not incremented.
REQ-024 SHALL, when HDR_BYPASS_EN is undefined, have no hdr_bypass port and insert a header into every packet.

Structure
REQ-025 SHALL place the FSM state typedef (IDLE/BODY/FLUSH) and the header field offsets (SEQ_OFS=0, MAGIC_OFS=4) in the shared package stream_hdr_pkg.
REQ-026 SHALL implement the keep-to-byte-count and count-to-keep conversions in one sub-module, keep_count, instantiated twice.

Verification
All scenarios use DW=128, HDR_BYTES=8, HDR_MAGIC=32'hC0DE0001.
REQ-027 SHALL cover: 1-beat packet, TKEEP=16'h00FF -> 1 output beat, TKEEP=16'hFFFF, bytes 0-3=0, bytes 4-7=01 00 DE C0, bytes 8-15=input bytes 0-7, TLAST=1.
REQ-028 SHALL cover: 1-beat packet, TKEEP=16'hFFFF -> 2 output beats, second with TKEEP=16'h00FF holding input bytes 8-15 and TLAST; IN_TREADY=0 during FLUSH.
REQ-029 SHALL cover: three 3-beat packets back-to-back -> sequence fields 0, 1, 2, with no idle cycle between packets whose last TKEEP=16'h00FF.
REQ-030 SHALL cover: random 50% OUT_TREADY over 200 packets -> output matches the golden model, with no lost or duplicated beats and stable data under stall.
REQ-031 SHALL cover: resetn low during the second beat of a packet -> all outputs 0 next cycle; the following packet carries sequence number 0.
REQ-032 SHALL cover, with HDR_BYPASS_EN: hdr_bypass=1 on a 2-beat packet -> output identical to input, and the next headed packet carries an unchanged sequence number.
